mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer for the EX stage of the SampleCPU pipeline. It accepts MULT/MULTU/DIV/DIVU operations from EX and runs the divider iteratively. While the operation is in flight it raises a stall request to the stall controller. On completion it produces the 66-bit HI/LO write bus {hi_we, lo_we, hi, lo} consumed by the HI/LO register file and its forwarding path.

---
 rtl/mdu_ctrl_pkg.sv | 25 ++
 rtl/mdu_ctrl_if.sv | 25 ++
 rtl/mdu_ctrl_div_core.sv | 51 +++++
 rtl/mdu_ctrl.sv | 134 +++++++++++++
 tb/tb_mdu_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the mul/div sequencer: op encodings, HI/LO bus width,
// FSM state encoding and the magnitude helper used by the signed paths.
package mdu_ctrl_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  localparam int unsigned HILO_BUS_W = 66;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  // Absolute value when the operand is treated as signed; 0x8000_0000 maps to itself.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-side handshake and HI/LO result bus of the mul/div sequencer.
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic                  start;
  logic [1:0]            op;
  logic [31:0]           src1;
  logic [31:0]           src2;
  logic                  cancel;
  logic                  hold;
  logic                  stallreq;
  logic                  busy;
  logic [HILO_BUS_W-1:0] hilo_bus;

  modport master (
    output start, op, src1, src2, cancel, hold,
    input  stallreq, busy, hilo_bus
  );

  modport slave (
    input  start, op, src1, src2, cancel, hold,
    output stallreq, busy, hilo_bus
  );

endinterface

// File: rtl/mdu_ctrl_div_core.sv
// Iterative restoring divider: {remainder, quotient} shift register, one step
// per cycle, with sign fix-up applied on the outputs.
module div_core
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic [63:0] sr;
  logic [31:0] dvs;
  logic        q_neg;
  logic        r_neg;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] sub;

  // rem_sh can reach 33 bits, but when ge holds the difference fits in 32.
  always_comb begin
    rem_sh = sr[63:31];
    ge     = rem_sh >= {1'b0, dvs};
    sub    = rem_sh[31:0] - dvs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (load) begin
      sr    <= {32'h0, mag32(dividend, is_signed)};
      dvs   <= mag32(divisor, is_signed);
      q_neg <= is_signed & (dividend[31] ^ divisor[31]);
      r_neg <= is_signed & dividend[31];
    end else if (step) begin
      sr <= ge ? {sub, sr[30:0], 1'b1} : {rem_sh[31:0], sr[30:0], 1'b0};
    end
  end

  assign quo = q_neg ? (~sr[31:0] + 32'd1)  : sr[31:0];
  assign rem = r_neg ? (~sr[63:32] + 32'd1) : sr[63:32];

endmodule

// File: rtl/mdu_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer for EX: FSM, iteration counter, stall request,
// multiply path and HI/LO bus. Define MDU_MUL_ITER_EN for iterative multiply.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned ITER = 32
) (
  input  logic       clk,
  input  logic       rst,
  mdu_ctrl_if.slave  mdu
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  mdu_state_e    state, state_nx;
  logic [CW-1:0] cnt;
  logic [63:0]   res;
  logic          use_div;
  logic          accept;
  logic          is_div_in;
  logic          signed_in;
  logic          dz_in;
  logic [31:0]   quo;
  logic [31:0]   rem;
  logic [63:0]   mul_val;
  logic [63:0]   hilo_val;

  assign accept    = (state == ST_IDLE) && mdu.start && !mdu.cancel;
  assign is_div_in = mdu.op[1];
  assign signed_in = !mdu.op[0];
  assign dz_in     = is_div_in && (mdu.src2 == 32'h0);

`ifdef MDU_MUL_ITER_EN
  logic [31:0] mcand;
  logic        mul_neg;
  logic [32:0] mul_sum;

  // Shift-add: res holds {partial product, remaining multiplier bits}.
  assign mul_sum = {1'b0, res[63:32]} + (res[0] ? {1'b0, mcand} : 33'h0);
  assign mul_val = mul_neg ? (~res + 64'd1) : res;
`else
  assign mul_val = res;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_div_in) begin
            state_nx = dz_in ? ST_DONE : ST_RUN;
          end else begin
`ifdef MDU_MUL_ITER_EN
            state_nx = ST_RUN;
`else
            state_nx = ST_DONE;
`endif
          end
        end
      end
      ST_RUN: begin
        if (mdu.cancel)                 state_nx = ST_IDLE;
        else if (cnt == CW'(ITER - 1))  state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (mdu.cancel || !mdu.hold) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      res     <= '0;
      use_div <= 1'b0;
`ifdef MDU_MUL_ITER_EN
      mcand   <= '0;
      mul_neg <= 1'b0;
`endif
    end else if (accept) begin
      cnt     <= '0;
      use_div <= is_div_in && !dz_in;
      if (dz_in) begin
        res <= {mdu.src1, 32'hFFFF_FFFF};
      end else if (!is_div_in) begin
`ifdef MDU_MUL_ITER_EN
        mcand   <= mag32(mdu.src1, signed_in);
        res     <= {32'h0, mag32(mdu.src2, signed_in)};
        mul_neg <= signed_in & (mdu.src1[31] ^ mdu.src2[31]);
`else
        res <= signed_in ? ({{32{mdu.src1[31]}}, mdu.src1} * {{32{mdu.src2[31]}}, mdu.src2})
                         : ({32'h0, mdu.src1} * {32'h0, mdu.src2});
`endif
      end
`ifdef MDU_MUL_ITER_EN
      else begin
        mul_neg <= 1'b0;
      end
`endif
    end else if (state == ST_RUN) begin
      cnt <= cnt + CW'(1);
`ifdef MDU_MUL_ITER_EN
      if (!use_div) res <= {mul_sum, res[31:1]};
`endif
    end
  end

  div_core u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && is_div_in),
    .step      ((state == ST_RUN) && use_div),
    .is_signed (signed_in),
    .dividend  (mdu.src1),
    .divisor   (mdu.src2),
    .quo       (quo),
    .rem       (rem)
  );

  always_comb begin
    hilo_val     = use_div ? {rem, quo} : mul_val;
    mdu.stallreq = accept || (state == ST_RUN);
    mdu.busy     = (state != ST_IDLE);
    mdu.hilo_bus = '0;
    if ((state == ST_DONE) && !mdu.cancel) mdu.hilo_bus = {2'b11, hilo_val};
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (divide, multiply, div-by-zero,
// overflow wrap, cancel, hold, reset).
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

`ifdef MDU_MUL_ITER_EN
  localparam int unsigned MUL_LAT = 33;
`else
  localparam int unsigned MUL_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mdu_ctrl_if bus();

  mdu_ctrl #(.ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start at T, expect DONE at T+lat with exp on the bus for one cycle.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int unsigned lat, input logic [65:0] exp);
    bus.start = 1'b1; bus.op = o; bus.src1 = a; bus.src2 = b;
    #1;
    chk({tag, ".stall_T"}, 66'(bus.stallreq), 66'd1);
    tick();
    bus.start = 1'b0; bus.src1 = ~a; bus.src2 = ~b;
    for (int unsigned i = 1; i < lat; i++) begin
      chk({tag, ".stall_run"}, 66'(bus.stallreq), 66'd1);
      chk({tag, ".bus_run"}, bus.hilo_bus, 66'd0);
      tick();
    end
    chk({tag, ".bus_done"}, bus.hilo_bus, exp);
    chk({tag, ".stall_done"}, 66'(bus.stallreq), 66'd0);
    chk({tag, ".busy_done"}, 66'(bus.busy), 66'd1);
    tick();
    chk({tag, ".bus_after"}, bus.hilo_bus, 66'd0);
    chk({tag, ".busy_after"}, 66'(bus.busy), 66'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.src1 = '0; bus.src2 = '0;
    bus.cancel = 1'b0; bus.hold = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("reset.stall", 66'(bus.stallreq), 66'd0);
    chk("reset.busy", 66'(bus.busy), 66'd0);
    chk("reset.bus", bus.hilo_bus, 66'd0);

    // Back-to-back directed ops.
    do_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 33, {2'b11, 32'h2, 32'hE});
    do_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 33, {2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op("div_5_0", MDU_DIV, 32'd5, 32'd0, 1, {2'b11, 32'h5, 32'hFFFF_FFFF});
    do_op("divu_7_0", MDU_DIVU, 32'd7, 32'd0, 1, {2'b11, 32'h7, 32'hFFFF_FFFF});
    do_op("mult_m1_3", MDU_MULT, 32'hFFFF_FFFF, 32'd3, MUL_LAT, {2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, {2'b11, 32'hFFFF_FFFE, 32'h0000_0001});
    do_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, {2'b11, 32'h0, 32'h8000_0000});
    do_op("div_m100_7", MDU_DIV, 32'hFFFF_FF9C, 32'd7, 33, {2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFF2});

    // Cancel in RUN at T+10, new start at T+11.
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.src1 = 32'd1000; bus.src2 = 32'd3;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      chk("cancel.bus_run", bus.hilo_bus, 66'd0);
      tick();
    end
    bus.cancel = 1'b1;
    #1;
    chk("cancel.bus_cycle", bus.hilo_bus, 66'd0);
    chk("cancel.stall_cycle", 66'(bus.stallreq), 66'd1);
    tick();
    bus.cancel = 1'b0;
    #1;
    chk("cancel.busy_after", 66'(bus.busy), 66'd0);
    chk("cancel.stall_after", 66'(bus.stallreq), 66'd0);
    do_op("after_cancel", MDU_DIVU, 32'd9, 32'd4, 33, {2'b11, 32'h1, 32'h2});

    // Hold in DONE for 3 cycles, start during DONE ignored.
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.src1 = 32'd50; bus.src2 = 32'd5;
    tick();
    bus.start = 1'b0;
    repeat (31) tick();
    chk("hold.bus_pre", bus.hilo_bus, 66'd0);
    tick();
    bus.hold = 1'b1; bus.start = 1'b1; bus.op = MDU_MULT; bus.src1 = 32'd3; bus.src2 = 32'd3;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold.bus", bus.hilo_bus, {2'b11, 32'h0, 32'hA});
      chk("hold.stall", 66'(bus.stallreq), 66'd0);
      tick();
    end
    bus.hold = 1'b0; bus.start = 1'b0;
    #1;
    chk("hold.bus_last", bus.hilo_bus, {2'b11, 32'h0, 32'hA});
    tick();
    chk("hold.busy_after", 66'(bus.busy), 66'd0);
    chk("hold.bus_after", bus.hilo_bus, 66'd0);

    // Cancel while presenting DONE suppresses the bus.
    bus.start = 1'b1; bus.op = MDU_DIV; bus.src1 = 32'd5; bus.src2 = 32'd0;
    tick();
    bus.start = 1'b0; bus.cancel = 1'b1;
    #1;
    chk("cancel_done.bus", bus.hilo_bus, 66'd0);
    chk("cancel_done.busy", 66'(bus.busy), 66'd1);
    tick();
    bus.cancel = 1'b0;
    #1;
    chk("cancel_done.busy_after", 66'(bus.busy), 66'd0);
    chk("cancel_done.bus_after", bus.hilo_bus, 66'd0);

    // start together with cancel in IDLE is not accepted.
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = MDU_DIVU; bus.src1 = 32'd8; bus.src2 = 32'd2;
    #1;
    chk("start_cancel.stall", 66'(bus.stallreq), 66'd0);
    tick();
    bus.start = 1'b0; bus.cancel = 1'b0;
    #1;
    chk("start_cancel.busy", 66'(bus.busy), 66'd0);

    // Reset mid-operation drops the op.
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.src1 = 32'd77; bus.src2 = 32'd5;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    chk("midrst.busy_pre", 66'(bus.busy), 66'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst.busy", 66'(bus.busy), 66'd0);
    chk("midrst.stall", 66'(bus.stallreq), 66'd0);
    chk("midrst.bus", bus.hilo_bus, 66'd0);
    do_op("after_rst", MDU_DIVU, 32'd20, 32'd6, 33, {2'b11, 32'h2, 32'h3});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
